// File: rtl/aes_req_queue.sv
// Request front-end for aes_build: buffers tagged encrypt/decrypt requests, issues them one
// at a time with a start pulse and returns the tagged result. AES_REQQ_TIMEOUT_EN adds a WAIT timeout.
module aes_req_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TMO_CYC = 255
) (
  input  logic             eph1,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_func,
  input  logic [127:0]     req_text,
  input  logic [127:0]     req_key,
  input  logic [TAG_W-1:0] req_tag,
  output logic             aes_start,
  output logic [1:0]       aes_func,
  output logic [127:0]     aes_text,
  output logic [127:0]     aes_key,
  input  logic             aes_done,
  input  logic [127:0]     aes_ct,
  input  logic [127:0]     aes_pt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [127:0]     rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic             busy
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  typedef struct packed {
    logic [1:0]       func;
    logic [127:0]     text;
    logic [127:0]     key;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  req_t             fifo_q [DEPTH];
  req_t             head;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [TAG_W-1:0] tag_q;
  logic             push, pop, load_head, load_illegal, capture, timeout, tmo_hit;

  assign req_ready = (count != CNT_FULL);
  assign push      = req_valid & req_ready;
  assign head      = fifo_q[rd_ptr];
  assign aes_start = (state_q == ISSUE);
  assign rsp_valid = (state_q == RESP);
  assign busy      = (count != '0) || (state_q != IDLE);

`ifdef AES_REQQ_TIMEOUT_EN
  localparam int unsigned      TMO_W    = ($clog2(TMO_CYC + 1) > 8) ? $clog2(TMO_CYC + 1) : 8;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0] tmo_cnt;

  // Fires on the TMO_CYC-th WAIT cycle without a completion.
  assign tmo_hit = (state_q == WAIT) && !aes_done && (tmo_cnt == TMO_LAST);

  always_ff @(posedge eph1) begin
    if (!reset_n)                tmo_cnt <= '0;
    else if (state_q == ISSUE)   tmo_cnt <= '0;
    else if (state_q == WAIT)    tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d      = state_q;
    pop          = 1'b0;
    load_head    = 1'b0;
    load_illegal = 1'b0;
    capture      = 1'b0;
    timeout      = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          if (head.func == 2'd3) begin
            pop          = 1'b1;
            load_illegal = 1'b1;
            state_d      = RESP;
          end else begin
            load_head = 1'b1;
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: begin
        pop     = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (aes_done) begin
          capture = 1'b1;
          state_d = RESP;
        end else if (tmo_hit) begin
          timeout = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it lives inside the clocked block rather than the sensitivity list.
  always_ff @(posedge eph1) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      aes_func <= '0;
      aes_text <= '0;
      aes_key  <= '0;
      tag_q    <= '0;
      rsp_data <= '0;
      rsp_tag  <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (load_head) begin
        aes_func <= head.func;
        aes_text <= head.text;
        aes_key  <= head.key;
        tag_q    <= head.tag;
      end
      if (load_illegal) begin
        rsp_data <= '0;
        rsp_tag  <= head.tag;
        rsp_err  <= 1'b1;
      end
      if (capture) begin
        rsp_data <= aes_func[0] ? aes_pt : aes_ct;
        rsp_tag  <= tag_q;
        rsp_err  <= 1'b0;
      end
      if (timeout) begin
        rsp_data <= '0;
        rsp_tag  <= tag_q;
        rsp_err  <= 1'b1;
      end
    end
  end

  // NOTE: storage has no reset; count and pointers alone decide which entries are valid.
  always_ff @(posedge eph1) begin
    if (push) fifo_q[wr_ptr] <= '{func: req_func, text: req_text, key: req_key, tag: req_tag};
  end

endmodule

// File: tb/tb_aes_req_queue.sv
// Self-checking bench for aes_req_queue: table-driven vectors, a scoreboard on the response port,
// a behavioural stand-in for aes_build, and hand sequences for timing, back-pressure and reset.
module tb_aes_req_queue;

  localparam int TAG_W = 4;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] XT  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [127:0] YK  = 128'hcafebabe0123456789abcdeffedcba98;

  logic             eph1 = 1'b0;
  logic             reset_n;
  logic             req_valid, req_ready;
  logic [1:0]       req_func;
  logic [127:0]     req_text, req_key;
  logic [TAG_W-1:0] req_tag;
  logic             aes_start;
  logic [1:0]       aes_func;
  logic [127:0]     aes_text, aes_key;
  logic             aes_done = 1'b0;
  logic [127:0]     aes_ct = '0, aes_pt = '0;
  logic             rsp_valid, rsp_ready;
  logic [127:0]     rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err, busy;

  aes_req_queue #(.DEPTH(4), .TAG_W(TAG_W), .TMO_CYC(20)) dut (
    .eph1(eph1), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
    .req_text(req_text), .req_key(req_key), .req_tag(req_tag),
    .aes_start(aes_start), .aes_func(aes_func), .aes_text(aes_text), .aes_key(aes_key),
    .aes_done(aes_done), .aes_ct(aes_ct), .aes_pt(aes_pt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .rsp_err(rsp_err), .busy(busy)
  );

  always #5 eph1 = ~eph1;

  typedef struct {
    logic [1:0]       func;
    logic [127:0]     text;
    logic [127:0]     key;
    logic [TAG_W-1:0] tag;
    logic [127:0]     exp_data;
    logic             exp_err;
  } vec_t;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [127:0]     data;
    logic             err;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[6];

  int   start_pulses = 0;
  int   core_lat = 3;
  int   core_cnt = 0;
  bit   core_busy = 1'b0;
  bit   core_en = 1'b1;
  bit   spur_done = 1'b0;

  logic         hold_pending = 1'b0;
  logic [159:0] held;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Known-answer pairs stand for real AES; anything else gets a distinct deterministic result.
  function automatic logic [127:0] enc_model(input logic [127:0] t, input logic [127:0] k);
    if (k == KEY && t == PT) return CT;
    return t ^ k;
  endfunction

  function automatic logic [127:0] dec_model(input logic [127:0] t, input logic [127:0] k);
    if (k == KEY && t == CT) return PT;
    return ~(t ^ k);
  endfunction

  // Stand-in for aes_build: latches on aes_start, raises aes_done core_lat+1 cycles later.
  always @(negedge eph1) begin
    aes_done = spur_done;
    if (reset_n !== 1'b1) begin
      core_busy = 1'b0;
    end else begin
      if (core_busy) begin
        if (core_cnt == 0) begin
          aes_done  = core_en | spur_done;
          core_busy = 1'b0;
        end else begin
          core_cnt--;
        end
      end
      if (aes_start === 1'b1) begin
        start_pulses++;
        core_busy = 1'b1;
        core_cnt  = core_lat;
        aes_ct    = enc_model(aes_text, aes_key);
        aes_pt    = dec_model(aes_text, aes_key);
      end
    end
  end

  // Response monitor: compares each handshake with the scoreboard and checks stalled outputs hold.
  always @(negedge eph1) begin
    if (reset_n !== 1'b1 || rsp_valid !== 1'b1) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) check("rsp_stable", {27'd0, rsp_data, rsp_tag, rsp_err}, held);
      if (rsp_ready) begin
        hold_pending = 1'b0;
        if (sb.size() == 0) begin
          check("rsp_unexpected", 1'b1, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          check("rsp_tag", rsp_tag, mon_e.tag);
          check("rsp_data", rsp_data, mon_e.data);
          check("rsp_err", rsp_err, mon_e.err);
        end
      end else begin
        hold_pending = 1'b1;
        held = {27'd0, rsp_data, rsp_tag, rsp_err};
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_req(input logic [1:0] f, input logic [127:0] t, input logic [127:0] k,
                          input logic [TAG_W-1:0] g, input logic [127:0] ed, input logic ee);
    int n = 0;
    req_valid = 1'b1;
    req_func  = f;
    req_text  = t;
    req_key   = k;
    req_tag   = g;
    @(negedge eph1);
    while (!req_ready && n < 300) begin
      @(negedge eph1);
      n++;
    end
    if (!req_ready) check("req_accept_timeout", 1'b0, 1'b1);
    else sb.push_back('{g, ed, ee});
    @(posedge eph1);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge eph1);
      n++;
    end while ((sb.size() != 0 || busy) && n < 500);
    check({name, "_drain"}, {sb.size() != 0, busy}, 2'b00);
    @(posedge eph1);
    #1;
  endtask

  task automatic check_reset_vals(input string p);
    check({p, "_ctl"}, {req_ready, aes_start, aes_func, rsp_valid, rsp_err, busy, rsp_tag},
          {1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0});
    check({p, "_aes_text"}, aes_text, 128'h0);
    check({p, "_aes_key"}, aes_key, 128'h0);
    check({p, "_rsp_data"}, rsp_data, 128'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int           base;
    logic [1:0]   last_func;
    logic [127:0] last_text, last_key;

    vecs[0] = '{2'd0, PT, KEY, 4'd5, CT, 1'b0};
    vecs[1] = '{2'd1, CT, KEY, 4'd9, PT, 1'b0};
    vecs[2] = '{2'd2, PT, KEY, 4'd3, CT, 1'b0};
    vecs[3] = '{2'd3, XT, YK, 4'd2, 128'h0, 1'b1};
    vecs[4] = '{2'd0, XT, YK, 4'd7, XT ^ YK, 1'b0};
    vecs[5] = '{2'd1, XT, YK, 4'hf, ~(XT ^ YK), 1'b0};

    reset_n = 1'b0; req_valid = 1'b0; req_func = '0; req_text = '0; req_key = '0;
    req_tag = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge eph1);
    #1 reset_n = 1'b1;
    @(negedge eph1);
    check_reset_vals("rst");
    @(posedge eph1);
    #1;

    // First-request latency: start pulse exactly one cycle, in the cycle after the head load.
    req_valid = 1'b1; req_func = 2'd0; req_text = XT; req_key = KEY; req_tag = 4'd1;
    sb.push_back('{4'd1, XT ^ KEY, 1'b0});
    @(posedge eph1);
    #1 req_valid = 1'b0;
    @(negedge eph1);
    check("lat_e_start", aes_start, 1'b0);
    check("lat_e_busy", busy, 1'b1);
    @(negedge eph1);
    check("lat_e1_start", aes_start, 1'b1);
    check("lat_head_text", aes_text, XT);
    @(negedge eph1);
    check("lat_e2_start", aes_start, 1'b0);
    wait_idle("lat");

    // Illegal func answers one edge after reaching the head, with no issue.
    base = start_pulses;
    req_valid = 1'b1; req_func = 2'd3; req_tag = 4'ha;
    sb.push_back('{4'ha, 128'h0, 1'b1});
    @(posedge eph1);
    #1 req_valid = 1'b0;
    @(negedge eph1);
    check("ill_e_valid", rsp_valid, 1'b0);
    @(negedge eph1);
    check("ill_e1_valid", rsp_valid, 1'b1);
    wait_idle("ill");
    check("ill_no_start", start_pulses - base, 0);

    last_func = 2'd0; last_text = XT; last_key = KEY;
    for (int i = 0; i < 6; i++) begin
      base = start_pulses;
      send_req(vecs[i].func, vecs[i].text, vecs[i].key, vecs[i].tag, vecs[i].exp_data, vecs[i].exp_err);
      wait_idle($sformatf("vec%0d", i));
      check($sformatf("vec%0d_starts", i), start_pulses - base, (vecs[i].func != 2'd3) ? 1 : 0);
      if (vecs[i].func != 2'd3) begin
        last_func = vecs[i].func; last_text = vecs[i].text; last_key = vecs[i].key;
      end
      check($sformatf("vec%0d_aes_regs", i), {aes_func, aes_text[63:0], aes_key[63:0]},
            {last_func, last_text[63:0], last_key[63:0]});
    end

    // A completion outside WAIT is ignored.
    base = start_pulses;
    spur_done = 1'b1;
    @(posedge eph1);
    @(posedge eph1);
    #1 spur_done = 1'b0;
    repeat (3) @(negedge eph1);
    check("spur_quiet", {rsp_valid, busy}, 2'b00);
    check("spur_starts", start_pulses - base, 0);
    @(posedge eph1);
    #1;

    // Back-pressure: four queued plus one in flight, then in-order drain.
    rsp_ready = 1'b0; core_lat = 2; base = start_pulses;
    for (int i = 0; i < 5; i++)
      send_req(2'd0, PT + 128'(i), KEY, TAG_W'(i), enc_model(PT + 128'(i), KEY), 1'b0);
    @(negedge eph1);
    check("bp_full_ready", req_ready, 1'b0);
    repeat (10) @(negedge eph1);
    check("bp_stall", {rsp_valid, req_ready, rsp_tag}, {1'b1, 1'b0, 4'd0});
    check("bp_one_start", start_pulses - base, 1);
    @(posedge eph1);
    #1 rsp_ready = 1'b1;
    wait_idle("bp");
    check("bp_starts", start_pulses - base, 5);

    // Reset while WAITing with two requests queued.
    core_lat = 10; base = start_pulses;
    send_req(2'd0, PT, KEY, 4'd1, CT, 1'b0);
    send_req(2'd0, PT, KEY, 4'd2, CT, 1'b0);
    send_req(2'd1, CT, KEY, 4'd3, PT, 1'b0);
    repeat (2) @(posedge eph1);
    check("rstw_pre", {rsp_valid, busy}, 2'b01);
    #1 reset_n = 1'b0;
    @(posedge eph1);
    #1 reset_n = 1'b1;
    sb.delete();
    @(negedge eph1);
    check_reset_vals("rstw");
    repeat (30) @(negedge eph1);
    check("rstw_quiet", {rsp_valid, busy}, 2'b00);
    check("rstw_starts", start_pulses - base, 1);
    @(posedge eph1);
    #1 core_lat = 3;
    send_req(2'd0, PT, KEY, 4'hc, CT, 1'b0);
    wait_idle("rstw_recover");

`ifdef AES_REQQ_TIMEOUT_EN
    // Timeout: 20 WAIT cycles without completion, then a late completion is ignored.
    core_en = 1'b0;
    req_valid = 1'b1; req_func = 2'd0; req_text = PT; req_key = KEY; req_tag = 4'd6;
    sb.push_back('{4'd6, 128'h0, 1'b1});
    @(posedge eph1);
    #1 req_valid = 1'b0;
    repeat (22) @(negedge eph1);
    check("tmo_before", rsp_valid, 1'b0);
    @(negedge eph1);
    check("tmo_at", rsp_valid, 1'b1);
    wait_idle("tmo");
    spur_done = 1'b1;
    @(posedge eph1);
    @(posedge eph1);
    #1 spur_done = 1'b0;
    repeat (3) @(negedge eph1);
    check("tmo_late_done", {rsp_valid, busy}, 2'b00);
    @(posedge eph1);
    #1 core_en = 1'b1;
    send_req(2'd1, CT, KEY, 4'd8, PT, 1'b0);
    wait_idle("tmo_recover");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
